// File: rtl/rv3n_dmem_sram_bridge_if.sv
// rtl/rv3n_dmem_sram_bridge_if.sv - LSU data-memory request/response bus
interface rv3n_dmem_sram_bridge_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_cmd;
    logic [1:0]      dmem_width;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_resp;
    logic            dmem_err;

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err
    );
endinterface

// File: rtl/rv3n_dmem_sram_bridge.sv
// rtl/rv3n_dmem_sram_bridge.sv - LSU dmem to single-port SRAM bridge (option: RV3N_DMEM_MISALIGN_ERR_EN)
module rv3n_dmem_sram_bridge #(
    parameter int XLEN    = 32,
    parameter int SRAM_AW = 14,
    parameter int WAIT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    rv3n_dmem_sram_bridge_if.slave dmem,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [3:0]             sram_be,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [XLEN-1:0]        sram_wdata,
    input  logic [XLEN-1:0]        sram_rdata
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_WAITS = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // With no wait states the LAT cycle is also the response cycle and no hold register is needed.
    localparam bit         HAS_WAIT = (WAIT > 0);
    localparam logic [2:0] WAIT_M1  = HAS_WAIT ? 3'(WAIT - 1) : 3'd0;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            cmd_q, cmd_d;
    logic [1:0]      width_q, width_d;
    logic [1:0]      off_q, off_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] hold_q, hold_d;

    logic            resp;
    logic            accept;
    logic            illegal;
    logic            misalign;
    logic            out_of_range;
    logic [XLEN-1:0] word_sel;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_data;

    // Classify the request on the bus and decide whether it is taken this cycle.
    always_comb begin
        out_of_range = (dmem.dmem_addr >> (SRAM_AW + 2)) != '0;
`ifdef RV3N_DMEM_MISALIGN_ERR_EN
        misalign = ((dmem.dmem_width == 2'd1) && dmem.dmem_addr[0]) ||
                   ((dmem.dmem_width == 2'd2) && (dmem.dmem_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        illegal = (dmem.dmem_width == 2'd3) || out_of_range || misalign;
        resp    = (state_q == ST_RESP) || ((state_q == ST_LAT) && !HAS_WAIT);
        accept  = rst && dmem.dmem_req && ((state_q == ST_IDLE) || resp);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured access attributes, wait counter and read-data hold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 3'd0;
            cmd_q   <= 1'b0;
            width_q <= 2'd0;
            off_q   <= 2'd0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            width_q <= width_d;
            off_q   <= off_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: an accept always restarts at LAT, even from the response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        width_d = width_q;
        off_d   = off_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            ST_LAT: begin
                if (HAS_WAIT) begin
                    hold_d  = sram_rdata;
                    cnt_d   = WAIT_M1;
                    state_d = (WAIT_M1 == 3'd0) ? ST_RESP : ST_WAITS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAITS: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (accept) begin
            state_d = ST_LAT;
            cmd_d   = dmem.dmem_cmd;
            width_d = dmem.dmem_width;
            off_d   = dmem.dmem_addr[1:0];
            err_d   = illegal;
        end
    end

    // SRAM strobes for the accepted access and the combinational response.
    always_comb begin
        sram_ce   = accept && !illegal;
        sram_we   = sram_ce && dmem.dmem_cmd;
        sram_addr = dmem.dmem_addr[SRAM_AW+1:2];
        sram_be   = 4'b0000;
        if (sram_ce) begin
            case (dmem.dmem_width)
                2'd0:    sram_be = 4'b0001 << dmem.dmem_addr[1:0];
                2'd1:    sram_be = 4'b0011 << {dmem.dmem_addr[1], 1'b0};
                default: sram_be = 4'b1111;
            endcase
        end
        case (dmem.dmem_width)
            2'd0:    sram_wdata = XLEN'({4{dmem.dmem_wdata[7:0]}});
            2'd1:    sram_wdata = XLEN'({2{dmem.dmem_wdata[15:0]}});
            default: sram_wdata = dmem.dmem_wdata;
        endcase

        word_sel = HAS_WAIT ? hold_q : sram_rdata;
        byte_sel = 8'(word_sel >> {off_q, 3'b000});
        half_sel = 16'(word_sel >> {off_q[1], 4'b0000});
        ld_data  = '0;
        case (width_q)
            2'd0:    ld_data[7:0]  = byte_sel;
            2'd1:    ld_data[15:0] = half_sel;
            default: ld_data       = word_sel;
        endcase

        dmem.dmem_resp  = resp;
        dmem.dmem_err   = resp && err_q;
        dmem.dmem_rdata = (resp && !cmd_q && !err_q) ? ld_data : '0;
    end
endmodule

// File: tb/tb_rv3n_dmem_sram_bridge.sv
// tb/tb_rv3n_dmem_sram_bridge.sv - bench for rv3n_dmem_sram_bridge at WAIT 0, 3 and 5
module tb_rv3n_dmem_sram_bridge;
    localparam int AW   = 14;
    localparam int NCMD = 17;

    typedef struct {
        bit          st;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        int          gap;
        bit          rst_after;
        bit          lit;
        bit          lit_err;
        logic [31:0] lit_rd;
        logic [3:0]  lit_be;
        logic [31:0] lit_wd;
    } cmd_t;

    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    cmd_t tbl [NCMD];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    function automatic cmd_t mk(bit st, logic [1:0] w, logic [31:0] a, logic [31:0] wd, int gap,
                                bit rst_after, bit lit, bit lit_err, logic [31:0] lit_rd,
                                logic [3:0] lit_be, logic [31:0] lit_wd);
        cmd_t c;
        c.st = st; c.w = w; c.a = a; c.wd = wd; c.gap = gap; c.rst_after = rst_after;
        c.lit = lit; c.lit_err = lit_err; c.lit_rd = lit_rd; c.lit_be = lit_be; c.lit_wd = lit_wd;
        return c;
    endfunction

    function automatic bit legal(cmd_t c);
        bit mis;
        mis = 1'b0;
`ifdef RV3N_DMEM_MISALIGN_ERR_EN
        mis = ((c.w == 2'd1) && (c.a % 2 != 0)) || ((c.w == 2'd2) && (c.a % 4 != 0));
`endif
        return (c.w != 2'd3) && (c.a < (32'd4 << AW)) && !mis;
    endfunction

    function automatic int base_of(cmd_t c);
        if (c.w == 2'd0) return int'(c.a);
        if (c.w == 2'd1) return int'(c.a) / 2 * 2;
        return int'(c.a) / 4 * 4;
    endfunction

    // Directed vectors: stores/loads, lane handling, errors, back-to-back and a reset-dropped load.
    initial begin
        tbl[0]  = mk(1, 2, 32'h10, 32'hDEADBEEF, 2, 0, 1, 0, 32'h0, 4'hF, 32'hDEADBEEF);
        tbl[1]  = mk(0, 2, 32'h10, 32'h0, 1, 0, 1, 0, 32'hDEADBEEF, 4'hF, 32'h0);
        tbl[2]  = mk(1, 0, 32'h13, 32'h000000A5, 0, 0, 1, 0, 32'h0, 4'h8, 32'hA5A5A5A5);
        tbl[3]  = mk(0, 0, 32'h13, 32'h0, 0, 0, 1, 0, 32'h000000A5, 4'h8, 32'h0);
        tbl[4]  = mk(1, 2, 32'h10, 32'h80017FFE, 1, 0, 1, 0, 32'h0, 4'hF, 32'h80017FFE);
        tbl[5]  = mk(0, 1, 32'h12, 32'h0, 1, 0, 1, 0, 32'h00008001, 4'hC, 32'h0);
        tbl[6]  = mk(0, 1, 32'h10, 32'h0, 0, 0, 1, 0, 32'h00007FFE, 4'h3, 32'h0);
        tbl[7]  = mk(0, 0, 32'h11, 32'h0, 0, 0, 1, 0, 32'h0000007F, 4'h2, 32'h0);
        tbl[8]  = mk(0, 3, 32'h10, 32'h0, 0, 0, 1, 1, 32'h0, 4'h0, 32'h0);
        tbl[9]  = mk(0, 2, 32'h00040000, 32'h0, 0, 0, 1, 1, 32'h0, 4'h0, 32'h0);
        tbl[10] = mk(1, 2, 32'h00, 32'h11223344, 1, 0, 1, 0, 32'h0, 4'hF, 32'h11223344);
`ifdef RV3N_DMEM_MISALIGN_ERR_EN
        tbl[11] = mk(0, 2, 32'h02, 32'h0, 0, 0, 1, 1, 32'h0, 4'h0, 32'h0);
`else
        tbl[11] = mk(0, 2, 32'h02, 32'h0, 0, 0, 1, 0, 32'h11223344, 4'hF, 32'h0);
`endif
        tbl[12] = mk(1, 1, 32'h06, 32'h0000BEEF, 0, 0, 1, 0, 32'h0, 4'hC, 32'hBEEFBEEF);
        tbl[13] = mk(0, 0, 32'h07, 32'h0, 0, 0, 1, 0, 32'h000000BE, 4'h8, 32'h0);
`ifdef RV3N_DMEM_MISALIGN_ERR_EN
        tbl[14] = mk(0, 1, 32'h13, 32'h0, 0, 0, 1, 1, 32'h0, 4'h0, 32'h0);
`else
        tbl[14] = mk(0, 1, 32'h13, 32'h0, 0, 0, 1, 0, 32'h00008001, 4'hC, 32'h0);
`endif
        tbl[15] = mk(0, 2, 32'h10, 32'h0, 1, 1, 0, 0, 32'h0, 4'h0, 32'h0);
        tbl[16] = mk(0, 2, 32'h10, 32'h0, 2, 0, 1, 0, 32'h80017FFE, 4'hF, 32'h0);
    end

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);

        logic            rst_n;
        logic            sram_ce;
        logic            sram_we;
        logic [3:0]      sram_be;
        logic [AW-1:0]   sram_addr;
        logic [31:0]     sram_wdata;
        logic [31:0]     sram_rdata;
        logic [31:0]     mem [256];
        logic [7:0]      ref_mem [1024];

        int   rem = 0;
        int   cyc = 0;
        int   cur = 0;
        bit   done = 1'b0;
        exp_t q[$];

        bit          seen     [NCMD];
        bit          got_err  [NCMD];
        logic [31:0] got_rd   [NCMD];
        logic [3:0]  got_be   [NCMD];
        logic [31:0] got_wd   [NCMD];
        int          acc_cyc  [NCMD];
        int          resp_cyc [NCMD];

        rv3n_dmem_sram_bridge_if #(.XLEN(32)) bus ();

        rv3n_dmem_sram_bridge #(.XLEN(32), .SRAM_AW(AW), .WAIT(W)) dut (
            .clk        (clk),
            .rst        (rst_n),
            .dmem       (bus),
            .sram_ce    (sram_ce),
            .sram_we    (sram_we),
            .sram_be    (sram_be),
            .sram_addr  (sram_addr),
            .sram_wdata (sram_wdata),
            .sram_rdata (sram_rdata)
        );

        function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
            logic [31:0] r;
            r = old;
            for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
            return r;
        endfunction

        // SRAM: read data one cycle after a ce read, garbage in every other cycle.
        always @(posedge clk) begin
            if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr[7:0]];
            else sram_rdata <= $urandom;
            if (sram_ce && sram_we) mem[sram_addr[7:0]] <= merge(mem[sram_addr[7:0]], sram_wdata, sram_be);
        end

        // Reference: byte-addressed memory, countdown to the response cycle and a response queue.
        initial begin
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    rem = 0;
                    q.delete();
                end else begin
                    if (rem == 1) void'(q.pop_front());
                    if (bus.dmem_req && rem <= 1) begin
                        cmd_t c;
                        exp_t e;
                        c = tbl[cur];
                        e.idx = cur;
                        e.err = !legal(c);
                        e.rd  = 32'h0;
                        if (!e.err) begin
                            for (int i = 0; i < (1 << c.w); i++) begin
                                if (c.st) ref_mem[(base_of(c) + i) % 1024] = 8'(c.wd >> (8 * i));
                                else e.rd = e.rd | (32'(ref_mem[(base_of(c) + i) % 1024]) << (8 * i));
                            end
                        end
                        q.push_back(e);
                        acc_cyc[cur] = cyc;
                        rem = 1 + W;
                    end else if (rem > 0) begin
                        rem = rem - 1;
                    end
                end
                cyc++;
            end
        end

        // Compare DUT outputs against the reference in the middle of every cycle.
        initial begin
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk($sformatf("L%0d rst_resp", g), 32'(bus.dmem_resp), 32'h0);
                    chk($sformatf("L%0d rst_err", g), 32'(bus.dmem_err), 32'h0);
                    chk($sformatf("L%0d rst_rdata", g), bus.dmem_rdata, 32'h0);
                    chk($sformatf("L%0d rst_ce", g), 32'(sram_ce), 32'h0);
                    chk($sformatf("L%0d rst_we", g), 32'(sram_we), 32'h0);
                    chk($sformatf("L%0d rst_be", g), 32'(sram_be), 32'h0);
                end else begin
                    cmd_t c;
                    bit   acc;
                    bit   exp_ce;
                    chk($sformatf("L%0d resp", g), 32'(bus.dmem_resp), 32'(rem == 1));
                    if (rem == 1 && q.size() > 0) begin
                        chk($sformatf("L%0d err#%0d", g, q[0].idx), 32'(bus.dmem_err), 32'(q[0].err));
                        chk($sformatf("L%0d rdata#%0d", g, q[0].idx), bus.dmem_rdata, q[0].rd);
                        seen[q[0].idx]     = 1'b1;
                        got_err[q[0].idx]  = bus.dmem_err;
                        got_rd[q[0].idx]   = bus.dmem_rdata;
                        resp_cyc[q[0].idx] = cyc;
                    end else begin
                        chk($sformatf("L%0d idle_rdata", g), bus.dmem_rdata, 32'h0);
                    end
                    c      = tbl[cur];
                    acc    = bus.dmem_req && rem <= 1;
                    exp_ce = acc && legal(c);
                    chk($sformatf("L%0d ce#%0d", g, cur), 32'(sram_ce), 32'(exp_ce));
                    if (acc) begin
                        got_be[cur] = sram_be;
                        got_wd[cur] = sram_wdata;
                    end
                    if (exp_ce) begin
                        logic [3:0] be;
                        be = 4'h0;
                        for (int i = 0; i < (1 << c.w); i++) be[(base_of(c) + i) % 4] = 1'b1;
                        chk($sformatf("L%0d we#%0d", g, cur), 32'(sram_we), 32'(c.st));
                        chk($sformatf("L%0d addr#%0d", g, cur), 32'(sram_addr), (c.a / 4) % (32'd1 << AW));
                        chk($sformatf("L%0d be#%0d", g, cur), 32'(sram_be), 32'(be));
                        if (c.st) begin
                            for (int i = 0; i < (1 << c.w); i++) begin
                                chk($sformatf("L%0d lane#%0d.%0d", g, cur, i),
                                    32'(8'(sram_wdata >> (8 * ((base_of(c) + i) % 4)))), 32'(8'(c.wd >> (8 * i))));
                            end
                        end
                    end
                end
            end
        end

        // Driver: presents each vector only in an idle or response cycle, then pins literals.
        initial begin
            rst_n = 1'b0;
            bus.dmem_req = 1'b0; bus.dmem_cmd = 1'b0; bus.dmem_width = 2'd0;
            bus.dmem_addr = 32'h0; bus.dmem_wdata = 32'h0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int i = 0; i < NCMD; i++) begin
                int guard;
                for (int k = 0; k < tbl[i].gap; k++) begin
                    @(posedge clk);
                    #1;
                end
                guard = 0;
                while (rem > 1 && guard < 64) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                if (guard >= 64) chk($sformatf("L%0d stall#%0d", g, i), 32'(guard), 32'h0);
                cur = i;
                bus.dmem_cmd   = tbl[i].st;
                bus.dmem_width = tbl[i].w;
                bus.dmem_addr  = tbl[i].a;
                bus.dmem_wdata = tbl[i].wd;
                bus.dmem_req   = 1'b1;
                @(posedge clk);
                #1 bus.dmem_req = 1'b0;
                if (tbl[i].rst_after) begin
                    @(posedge clk);
                    #1 rst_n = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                end
            end
            repeat (12) @(posedge clk);
            #1;
            for (int i = 0; i < NCMD; i++) begin
                if (tbl[i].lit) begin
                    chk($sformatf("L%0d lit_seen#%0d", g, i), 32'(seen[i]), 32'h1);
                    chk($sformatf("L%0d lit_err#%0d", g, i), 32'(got_err[i]), 32'(tbl[i].lit_err));
                    chk($sformatf("L%0d lit_rdata#%0d", g, i), got_rd[i], tbl[i].lit_rd);
                    chk($sformatf("L%0d lit_be#%0d", g, i), 32'(got_be[i]), 32'(tbl[i].lit_be));
                    if (tbl[i].st) chk($sformatf("L%0d lit_wdata#%0d", g, i), got_wd[i], tbl[i].lit_wd);
                end
            end
            chk($sformatf("L%0d reset_drop", g), 32'(seen[15]), 32'(W == 0));
            chk($sformatf("L%0d load_latency", g), 32'(resp_cyc[1] - acc_cyc[1]), 32'(1 + W));
            done = 1'b1;
        end
    end

    // Wait for all lanes with a cycle budget, then report.
    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) chk("timeout", 32'(t), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
